// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Bridges execute-stage byte-addressed load/store requests onto a
//             single-word synchronous data memory port. Handles byte/half/word
//             loads with sign or zero extension, word stores directly, and
//             byte/half stores as read-modify-write. Flags misaligned,
//             out-of-range and illegal-size requests without touching memory.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             req_valid/req_ready        - request handshake
//             req_wen, req_size,
//             req_signed, req_addr,
//             req_wdata                  - request fields
//             resp_valid/resp_ready      - response handshake
//             resp_rdata, resp_err       - response fields
//             mem_en, mem_wen, mem_addr,
//             mem_wdata, mem_rdata       - data memory port (1-cycle read)
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W+1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_wen;
    logic [31:0]         r_wdata;    // store data; becomes the merged word in CAP
    logic [31:0]         r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_req_err;
    logic                w_addr_hi_nz;
    logic [4:0]          w_shift;
    logic [15:0]         w_lane;
    logic [31:0]         w_load;
    logic [31:0]         w_mask;
    logic [31:0]         w_merged;
    logic                w_mem_active;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Any byte address beyond the memory's reach is rejected up front.
    assign w_addr_hi_nz = (req_addr >> (ADDR_W + 2)) != 32'd0;

    always_comb begin
        w_req_err = 1'b0;
        case (req_size)
            c_SIZE_BYTE: w_req_err = 1'b0;
            c_SIZE_HALF: w_req_err = req_addr[0];
            c_SIZE_WORD: w_req_err = |req_addr[1:0];
            default:     w_req_err = 1'b1;
        endcase
        w_req_err = w_req_err | w_addr_hi_nz;
    end

    // Little-endian lane select: shift the addressed byte/half down to bit 0.
    assign w_shift = {r_addr[1:0], 3'b000};
    assign w_lane  = 16'(mem_rdata >> w_shift);

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
            c_SIZE_HALF: w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default:     w_load = mem_rdata;
        endcase
    end

    // Sub-word store merge: replace only the addressed lane, keep the rest.
    assign w_mask   = ((r_size == c_SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_state_nxt = S_RESP;
                    else if (req_wen && (req_size == c_SIZE_WORD))
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_RD:    w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = r_wen ? S_WR : S_RESP;
            S_WR:    w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = resp_ready ? S_IDLE : S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_wen    <= 1'b0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr   <= req_addr[ADDR_W+1:0];
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wen    <= req_wen;
                r_wdata  <= req_wdata;
                r_rdata  <= 32'd0;
                r_err    <= w_req_err;
            end else if (r_state == S_CAP) begin
                // mem_rdata is only trustworthy here; the memory blanks it afterwards.
                if (r_wen)
                    r_wdata <= w_merged;
                else
                    r_rdata <= w_load;
            end
        end
    end

    // Outputs depend only on state and captured registers.
    assign w_mem_active = (r_state == S_RD) || (r_state == S_WR);

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
    assign resp_err   = (r_state == S_RESP) ? r_err   : 1'b0;
    assign mem_en     = w_mem_active;
    assign mem_wen    = (r_state == S_WR);
    assign mem_addr   = w_mem_active ? r_addr[ADDR_W+1:2] : '0;
    assign mem_wdata  = (r_state == S_WR) ? r_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit. A byte-array reference
//             memory predicts responses, memory write words and latencies;
//             a word-array memory model sits on the DUT memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W = 8;
    localparam int NBYTES = 4 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Physical memory on the DUT port: 1-cycle read, output cleared when idle.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en && mem_wen)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_wen) ? mem[mem_addr] : 32'd0;
    end

    // Reference: byte-addressed memory image plus the expected outcome of the
    // request currently in flight.
    logic [7:0]        ref_mem [0:NBYTES-1];
    bit                exp_active = 1'b0;
    logic [31:0]       exp_rdata;
    logic              exp_err;
    logic [31:0]       exp_wword;
    logic [ADDR_W-1:0] exp_waddr;
    logic [7:0]        exp_bytes [4];
    int                exp_base;
    int                exp_lat, exp_rd, exp_wr;
    int                n_rd, n_wr;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(input logic wen, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int     nb;
        longint v;
        nb        = 1 << size;
        exp_err   = (size == 2'd3) || ((addr & 32'(nb - 1)) != 0) || (addr >= 32'(NBYTES));
        exp_rdata = 32'd0;
        exp_wword = 32'd0;
        exp_rd    = 0;
        exp_wr    = 0;
        exp_lat   = 1;
        exp_waddr = addr[ADDR_W+1:2];
        exp_base  = 0;
        if (!exp_err) begin
            exp_base = int'(addr) & ~3;
            for (int i = 0; i < 4; i++) exp_bytes[i] = ref_mem[exp_base + i];
            if (!wen) begin
                v = 0;
                for (int i = 0; i < nb; i++)
                    v = v | (longint'(ref_mem[int'(addr) + i]) << (8 * i));
                if (sgn && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1)
                    v = v - (longint'(1) << (8 * nb));
                exp_rdata = 32'(v);
                exp_rd    = 1;
                exp_lat   = 3;
            end else begin
                for (int i = 0; i < nb; i++)
                    exp_bytes[int'(addr[1:0]) + i] = wdata[8*i +: 8];
                exp_wword = {exp_bytes[3], exp_bytes[2], exp_bytes[1], exp_bytes[0]};
                exp_wr    = 1;
                exp_rd    = (nb < 4) ? 1 : 0;
                exp_lat   = (nb < 4) ? 4 : 2;
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the in-flight expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("resp_without_request", {63'd0, resp_valid & ~exp_active}, 64'd0);
            if (resp_valid && exp_active) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err",   resp_err,   exp_err);
                chk("req_ready_in_resp", req_ready, 0);
            end
            if (mem_en) begin
                chk("mem_addr", mem_addr, exp_waddr);
                if (mem_wen) begin
                    chk("mem_wdata", mem_wdata, exp_wword);
                    n_wr++;
                end else begin
                    n_rd++;
                end
            end else begin
                chk("mem_idle_outputs", {mem_wen, mem_addr, mem_wdata}, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_req_ready",  req_ready,  1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err",   resp_err,   0);
        chk("rst_mem_en",     mem_en,     0);
        chk("rst_mem_wen",    mem_wen,    0);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_mem_wdata",  mem_wdata,  0);
    endtask

    task automatic run_req(input logic wen, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input bit lit_on, input logic [31:0] lit,
                           input bit rst_in_cap);
        int lat;
        @(negedge clk);
        model_eval(wen, size, sgn, addr, wdata);
        if (lit_on) chk("model_literal", wen ? exp_wword : exp_rdata, lit);
        chk("req_ready_idle", req_ready, 1);
        n_rd       = 0;
        n_wr       = 0;
        exp_active = 1'b1;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_wen    = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (rst_in_cap) begin
            @(negedge clk);              // CAP cycle
            rst_n = 1'b0;
            #1;
            check_reset_outputs();
            exp_active = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("no_resp_after_reset", resp_valid, 0);
            end
            return;
        end
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            chk("req_ready_hold", req_ready, 0);
            @(negedge clk);
            chk("resp_valid_hold", resp_valid, 1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        exp_active = 1'b0;
        chk("req_ready_after_resp", req_ready, 1);
        chk("mem_read_cycles",  n_rd, exp_rd);
        chk("mem_write_cycles", n_wr, exp_wr);
        if (!exp_err && wen)
            for (int i = 0; i < 4; i++) ref_mem[exp_base + i] = exp_bytes[i];
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        for (int w = 0; w < (1 << ADDR_W); w++) begin
            mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem[w][8*b +: 8];
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Directed cases with hand-computed values.
        run_req(1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0);
        chk("pin_waddr_0x010", exp_waddr, 4);
        run_req(0, 2'd2, 0, 32'h010, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        run_req(0, 2'd0, 1, 32'h013, 32'h0, 0, 1, 32'hFFFFFFDE, 0);
        run_req(0, 2'd1, 0, 32'h010, 32'h0, 0, 1, 32'h0000BEEF, 0);
        run_req(0, 2'd1, 1, 32'h012, 32'h0, 0, 1, 32'hFFFFDEAD, 0);
        run_req(1, 2'd0, 0, 32'h011, 32'h1234565A, 0, 1, 32'hDEAD5AEF, 0);
        run_req(0, 2'd2, 0, 32'h010, 32'h0, 0, 1, 32'hDEAD5AEF, 0);
        // Error cases: misaligned half, out-of-range word, illegal size.
        run_req(0, 2'd1, 0, 32'h011, 32'h0, 0, 0, 32'h0, 0);
        run_req(1, 2'd2, 0, 32'h402, 32'h12345678, 0, 0, 32'h0, 0);
        run_req(0, 2'd3, 0, 32'h000, 32'h0, 0, 0, 32'h0, 0);
        // Response backpressure.
        run_req(0, 2'd2, 0, 32'h010, 32'h0, 3, 1, 32'hDEAD5AEF, 0);
        // Reset during CAP of a byte store, then confirm memory untouched.
        run_req(1, 2'd0, 0, 32'h010, 32'h00000077, 0, 0, 32'h0, 1);
        run_req(0, 2'd2, 0, 32'h010, 32'h0, 0, 1, 32'hDEAD5AEF, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            a  = (r == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) != 0 && sz == 2'd1) a[0] = 1'b0;
            if ($urandom_range(0, 3) != 0 && sz == 2'd2) a[1:0] = 2'b00;
            run_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                    $urandom_range(0, 3), 0, 32'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
